register_file: RTL and testbench

Parametrised multi-port register file with a per-entry busy scoreboard, the successor to the single 32-bit enable register. Holds DEPTH words of WIDTH bits, serves two combinational read ports with write-to-read bypass, and tracks outstanding writes so decode can stall on operands whose producer has not yet written back. Sits between decode (read, reserve) and writeback (write) in the processor pipeline.

---
 rtl/register_file.sv | 104 ++++++++++
 tb/tb_register_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file with two combinational read
// ports, write-to-read bypass, and a per-entry busy scoreboard that marks
// entries whose producer has been reserved but not yet written back.
module register_file #(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic             ra_busy,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_busy,
    input  logic             res_en,
    input  logic [AW-1:0]    res_addr,
    input  logic             we,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data
);

    typedef struct packed {
        logic             busy;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // Writes and reservations aimed at the hardwired zero entry are dropped.
    logic wr_ok;
    logic res_ok;

    assign wr_ok  = we     && !(ZERO_REG && (w_addr   == '0));
    assign res_ok = res_en && !(ZERO_REG && (res_addr == '0));

    // Resolve one read port: zero entry, then bypass from writeback, then storage.
    function automatic rd_t read_port(input logic [AW-1:0] addr);
        rd_t r;
        r.busy = 1'b0;
        r.data = '0;
        if (!rst_n || (ZERO_REG && (addr == '0))) begin
            r.busy = 1'b0;
            r.data = '0;
        end else if (we && (w_addr == addr)) begin
            r.data = w_data;
            r.busy = res_en && (res_addr == addr);
        end else begin
            r.data = mem[addr];
            r.busy = busy[addr];
        end
        return r;
    endfunction

    // Data storage: written at writeback.
    // NOTE: the array is cleared on reset because reads of never-written
    // entries must return 0; this costs a reset net per flop, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so readers and writers never race in simulation.
            mem[w_addr] <= w_data;
        end
    end

    // Busy scoreboard: writeback clears, reserve sets; reserve is applied
    // last so a same-edge write+reserve to one entry leaves it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[w_addr] <= 1'b0;
            end
            if (res_ok) begin
                busy[res_addr] <= 1'b1;
            end
        end
    end

    // Read port A.
    always_comb begin
        rd_t r;
        r       = read_port(ra_addr);
        ra_data = r.data;
        ra_busy = r.busy;
    end

    // Read port B.
    always_comb begin
        rd_t r;
        r       = read_port(rb_addr);
        rb_data = r.data;
        rb_busy = r.busy;
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives two register_file instances (32x32 with zero
// register, 4x8 without) from shared random stimulus and compares them every
// cycle against an array-based model, plus directed literal checks.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ra_addr = '0, rb_addr = '0, res_addr = '0, w_addr = '0;
    logic        res_en = 1'b0, we = 1'b0;
    logic [31:0] w_data = '0;

    logic [31:0] ra_data, rb_data;
    logic        ra_busy, rb_busy;
    logic [7:0]  sa_data, sb_data;
    logic        sa_busy, sb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut_big (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .res_en(res_en), .res_addr(res_addr),
        .we(we), .w_addr(w_addr), .w_data(w_data)
    );

    register_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b0)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr[1:0]), .ra_data(sa_data), .ra_busy(sa_busy),
        .rb_addr(rb_addr[1:0]), .rb_data(sb_data), .rb_busy(sb_busy),
        .res_en(res_en), .res_addr(res_addr[1:0]),
        .we(we), .w_addr(w_addr[1:0]), .w_data(w_data[7:0])
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Instance 0: 32 entries, 32 bits, zero register. Instance 1: 4 entries, 8 bits.
    logic [31:0] m_data [2][32];
    bit          m_busy [2][32];
    int          dep [2] = '{32, 4};
    logic [31:0] msk [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    bit          zr  [2] = '{1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_data[k][i] = '0;
                m_busy[k][i] = 1'b0;
            end
    endfunction

    // Expected {busy, data} seen by a read port of instance k at raw address addr.
    function automatic logic [32:0] exp_port(input int k, input int addr);
        logic [32:0] r;
        int a;
        a = addr % dep[k];
        r = '0;
        if (!rst_n || (zr[k] && a == 0)) return r;
        if (we && (int'(w_addr) % dep[k]) == a) begin
            r[31:0] = w_data & msk[k];
            r[32]   = res_en && ((int'(res_addr) % dep[k]) == a);
        end else begin
            r[31:0] = m_data[k][a];
            r[32]   = m_busy[k][a];
        end
        return r;
    endfunction

    function automatic void model_edge();
        int wa, rs;
        for (int k = 0; k < 2; k++) begin
            wa = int'(w_addr) % dep[k];
            rs = int'(res_addr) % dep[k];
            if (we && !(zr[k] && wa == 0)) begin
                m_data[k][wa] = w_data & msk[k];
                m_busy[k][wa] = 1'b0;
            end
            if (res_en && !(zr[k] && rs == 0))
                m_busy[k][rs] = 1'b1;
        end
    endfunction

    // Compare process: check all ports at every falling edge, advance the
    // model on every rising edge (or clear it while reset is held).
    initial begin
        logic [32:0] e;
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) model_clear();
            e = exp_port(0, ra_addr); check("big_ra_data", ra_data, e[31:0]); check("big_ra_busy", {31'b0, ra_busy}, {31'b0, e[32]});
            e = exp_port(0, rb_addr); check("big_rb_data", rb_data, e[31:0]); check("big_rb_busy", {31'b0, rb_busy}, {31'b0, e[32]});
            e = exp_port(1, ra_addr); check("small_ra_data", {24'b0, sa_data}, e[31:0]); check("small_ra_busy", {31'b0, sa_busy}, {31'b0, e[32]});
            e = exp_port(1, rb_addr); check("small_rb_data", {24'b0, sb_data}, e[31:0]); check("small_rb_busy", {31'b0, sb_busy}, {31'b0, e[32]});
            @(posedge clk);
            if (!rst_n) model_clear();
            else        model_edge();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; res_en = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        #2 rst_n = 1'b1;

        // Write then read from storage on both ports.
        tick(); we = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
        tick(); idle(); ra_addr = 5'd5; rb_addr = 5'd5; #1;
        check("wr_rd_a", ra_data, 32'hDEAD_BEEF);
        check("wr_rd_b", rb_data, 32'hDEAD_BEEF);
        check("wr_rd_busy", {31'b0, ra_busy | rb_busy}, 32'd0);

        // Bypass: entry 7 holds 0x11, same-cycle write of 0x22 is seen.
        tick(); we = 1'b1; w_addr = 5'd7; w_data = 32'h11;
        tick(); w_data = 32'h22; ra_addr = 5'd7; rb_addr = 5'd8; #1;
        check("bypass_a", ra_data, 32'h22);
        check("bypass_b_other", rb_data, 32'h0);
        tick(); idle(); #1;
        check("bypass_stored", ra_data, 32'h22);

        // Scoreboard: reserve 3, busy the next cycle, cleared by writeback.
        tick(); res_en = 1'b1; res_addr = 5'd3; ra_addr = 5'd3; #1;
        check("res_not_bypassed", {31'b0, ra_busy}, 32'd0);
        tick(); idle(); #1;
        check("res_busy", {31'b0, ra_busy}, 32'd1);
        tick(); we = 1'b1; w_addr = 5'd3; w_data = 32'h55; #1;
        check("wb_busy_clear", {31'b0, ra_busy}, 32'd0);
        check("wb_data", ra_data, 32'h55);
        tick(); idle(); #1;
        check("wb_busy_after", {31'b0, ra_busy}, 32'd0);
        check("wb_data_after", ra_data, 32'h55);

        // Simultaneous write and reserve to 9: new producer wins.
        tick(); we = 1'b1; res_en = 1'b1; w_addr = 5'd9; res_addr = 5'd9; w_data = 32'hA5; rb_addr = 5'd9; #1;
        check("sim_bypass_busy", {31'b0, rb_busy}, 32'd1);
        tick(); idle(); #1;
        check("sim_data", rb_data, 32'hA5);
        check("sim_busy", {31'b0, rb_busy}, 32'd1);

        // Zero register (big) versus plain entry 0 (small).
        tick(); we = 1'b1; res_en = 1'b1; w_addr = 5'd0; res_addr = 5'd0; w_data = 32'hFFFF_FFFF;
        ra_addr = 5'd0; rb_addr = 5'd0; #1;
        check("zero_same_data", ra_data, 32'h0);
        check("zero_same_busy", {31'b0, ra_busy}, 32'd0);
        check("small0_bypass", {24'b0, sa_data}, 32'hFF);
        tick(); idle(); #1;
        check("zero_next_data", ra_data, 32'h0);
        check("zero_next_busy", {31'b0, ra_busy}, 32'd0);
        check("small0_stored", {24'b0, sa_data}, 32'hFF);
        check("small0_busy", {31'b0, sa_busy}, 32'd1);

        // Mid-cycle reset with a write in flight.
        tick(); we = 1'b1; w_addr = 5'd2; w_data = 32'h1234; ra_addr = 5'd2; rb_addr = 5'd9; #1;
        check("pre_rst_bypass", ra_data, 32'h1234);
        #1 rst_n = 1'b0; #1;
        check("rst_a_data", ra_data, 32'h0);
        check("rst_b_data", rb_data, 32'h0);
        check("rst_b_busy", {31'b0, rb_busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick(); ra_addr = 5'(i); rb_addr = 5'((i + 9) % 32);
            we = 1'b1; w_addr = 5'(i); w_data = $urandom; res_en = 1'b1; res_addr = 5'(i); #1;
            check("rst_hold_data", ra_data | rb_data, 32'h0);
            check("rst_hold_busy", {31'b0, ra_busy | rb_busy | sa_busy | sb_busy}, 32'd0);
        end
        tick(); idle(); #3 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick(); ra_addr = 5'(i); rb_addr = 5'(31 - i); #1;
            check("post_rst_data", ra_data | rb_data, 32'h0);
        end

        // Randomized traffic; half the addresses crowd a few entries for collisions.
        for (int n = 0; n < 3000; n++) begin
            tick();
            we       = ($urandom_range(0, 1) == 1);
            res_en   = ($urandom_range(0, 2) == 0);
            w_addr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            res_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra_addr  = ($urandom_range(0, 1) == 1) ? w_addr : 5'($urandom);
            rb_addr  = ($urandom_range(0, 1) == 1) ? res_addr : 5'($urandom);
            w_data   = $urandom;
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                tick(); #2 rst_n = 1'b1;
            end
        end
        tick(); idle();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
